// File: rtl/led_pwm_driver.sv
// LED output stage: global brightness PWM and per-LED blinking applied to the PIO pattern,
// configured through a small Avalon-MM register slave.
module led_pwm_driver #(
  parameter int WIDTH    = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pattern_in,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  led_out
);

  localparam int                  PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] bright_act;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [WIDTH-1:0]    blink_mask;
  logic [15:0]         blink_per;
  logic [15:0]         blink_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [WIDTH-1:0]    pat_p0;
  logic                phase;
  logic                tick;
  logic                pend;
  logic                pwm_on;
  logic                wr_en;
  logic                wr_per;
  logic                unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wr_per    = wr_en && (address == 2'd2);
  assign tick      = (pre_cnt == PRE_LAST);
  assign pend      = tick && (pwm_cnt == PWM_MAX);
  assign pwm_on    = (bright_act == PWM_MAX) || (pwm_cnt < bright_act);
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright     <= '1;
      blink_mask <= '0;
      blink_per  <= '0;
    end else if (wr_en) begin
      case (address)
        2'd0:    bright     <= writedata[PWM_BITS-1:0];
        2'd1:    blink_mask <= writedata[WIDTH-1:0];
        2'd2:    blink_per  <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Shadow brightness is only adopted at a period boundary so no PWM pulse is ever truncated.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      bright_act <= '1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (pend) bright_act <= bright;
    end
  end

  // A BLINKPER write restarts the blink cycle in the lit phase, even on a period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr_per || (blink_per == 16'd0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (pend) begin
      if (blink_cnt == blink_per - 16'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Stage p0: capture PIO pattern; output stage: gate with PWM and blink.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_p0  <= '0;
      led_out <= '0;
    end else begin
      pat_p0  <= pattern_in;
      led_out <= pat_p0 & {WIDTH{pwm_on}} & (~blink_mask | {WIDTH{phase}});
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[PWM_BITS-1:0] = bright;
      2'd1:    readdata[WIDTH-1:0]    = blink_mask;
      2'd2:    readdata[15:0]         = blink_per;
      default: readdata[PWM_BITS:0]   = {phase, pwm_cnt};
    endcase
  end

endmodule
